sensor_poll_ctrl: RTL and testbench

- Scheduler that shares one 3-bit sensor read port among NUM_SENSORS sensors.
- Polls the sensors round-robin over a req/ack handshake and classifies each reading with wildcard priority rules:
  - 1?? means OK.
  - ?11 means FAULT.
  - Anything else means UNKNOWN.
- Debounces faults per sensor and publishes per-sensor ok/fault flags to the system health logic.

---
 rtl/sensor_poll_ctrl_pkg.sv | 28 ++
 rtl/sensor_poll_ctrl_if.sv | 15 +
 rtl/sensor_poll_ctrl_classifier.sv | 13 +
 rtl/sensor_poll_ctrl.sv | 149 ++++++++++++++
 tb/tb_sensor_poll_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_poll_ctrl_pkg.sv
// Shared types and the reading classifier for the sensor poll controller.
// Purely combinational helpers; no latency, no backpressure.
package sensor_pkg;

  typedef enum logic [1:0] {
    CLS_OK,
    CLS_FAULT,
    CLS_UNKNOWN
  } sensor_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_EVAL
  } poll_state_e;

  // First matching pattern wins, so 3'b111 lands on OK rather than FAULT.
  function automatic sensor_class_e classify(input logic [2:0] data);
    sensor_class_e cls;
    casez (data)
      3'b1??:  cls = CLS_OK;
      3'b?11:  cls = CLS_FAULT;
      default: cls = CLS_UNKNOWN;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/sensor_poll_ctrl_if.sv
// Shared sensor read port: controller drives sel/req, sensor mux returns ack/data.
// Handshake: data_i is valid in the cycle ack_i is high while req_o is high.
interface sensor_poll_ctrl_if #(
  parameter int NUM_SENSORS = 4
) ();
  localparam int SEL_W = $clog2(NUM_SENSORS);

  logic [SEL_W-1:0] sel_o;
  logic             req_o;
  logic             ack_i;
  logic [2:0]       data_i;

  modport master (output sel_o, output req_o, input ack_i, input data_i);
  modport slave  (input sel_o, input req_o, output ack_i, output data_i);
endinterface

// File: rtl/sensor_poll_ctrl_classifier.sv
// Maps a captured reading (or a timed-out transaction) to OK/FAULT/UNKNOWN.
// Combinational, zero latency; a timeout always classifies as FAULT.
module sensor_classifier
  import sensor_pkg::*;
(
  input  logic [2:0]    data_i,
  input  logic          timeout_i,
  output sensor_class_e cls_o
);

  assign cls_o = timeout_i ? CLS_FAULT : classify(data_i);

endmodule

// File: rtl/sensor_poll_ctrl.sv
// Round-robin poller for NUM_SENSORS sensors on one shared read port; debounces faults.
// Best case 2 cycles per sensor; a silent sensor is abandoned after TIMEOUT wait cycles.
module sensor_poll_ctrl
  import sensor_pkg::*;
#(
  parameter int NUM_SENSORS  = 4,
  parameter int FAULT_THRESH = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  sensor_poll_ctrl_if.master     bus,
  output logic [NUM_SENSORS-1:0] ok_o,
  output logic [NUM_SENSORS-1:0] fault_o,
  output logic                   scan_done_o,
  output logic                   timeout_o
);

  localparam int SEL_W  = $clog2(NUM_SENSORS);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W  = $clog2(FAULT_THRESH + 1);

  localparam logic [SEL_W-1:0]  LAST_SEL   = SEL_W'(NUM_SENSORS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(FAULT_THRESH);

  poll_state_e            state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [2:0]             data_q, data_d;
  logic                   tmo_q, tmo_d;
  logic                   done_q, done_d;
  logic [NUM_SENSORS-1:0] ok_q, ok_d;
  logic [NUM_SENSORS-1:0] fault_q, fault_d;
  logic [CNT_W-1:0]       cnt_q [NUM_SENSORS];
  logic [CNT_W-1:0]       cnt_d [NUM_SENSORS];

  logic                   req;
  logic                   wait_expired;
  logic [CNT_W-1:0]       cnt_inc;
  sensor_class_e          cls;

  // tmo_q is high exactly during the EVAL cycle that follows a timeout.
  sensor_classifier u_classifier (
    .data_i    (data_q),
    .timeout_i (tmo_q),
    .cls_o     (cls)
  );

  assign wait_expired = (wait_q == WAIT_LIMIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack in the threshold cycle still counts as an ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_REQ;
      ST_REQ:  if (bus.ack_i || wait_expired) state_d = ST_EVAL;
      ST_EVAL: state_d = enable ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req = (state_q == ST_REQ);
  end

  assign bus.req_o   = req;
  assign bus.sel_o   = sel_q;
  assign ok_o        = ok_q;
  assign fault_o     = fault_q;
  assign scan_done_o = done_q;
  assign timeout_o   = tmo_q;

  always_comb begin
    sel_d   = sel_q;
    wait_d  = '0;
    data_d  = data_q;
    tmo_d   = 1'b0;
    done_d  = 1'b0;
    ok_d    = ok_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q[sel_q] == CNT_MAX) ? CNT_MAX : cnt_q[sel_q] + 1'b1;

    unique case (state_q)
      ST_REQ: begin
        if (bus.ack_i) begin
          data_d = bus.data_i;
        end else if (wait_expired) begin
          tmo_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_EVAL: begin
        done_d = (sel_q == LAST_SEL);
        sel_d  = (enable && (sel_q != LAST_SEL)) ? sel_q + 1'b1 : '0;
        unique case (cls)
          CLS_OK: begin
            ok_d[sel_q]    = 1'b1;
            fault_d[sel_q] = 1'b0;
            cnt_d[sel_q]   = '0;
          end
          CLS_FAULT: begin
            ok_d[sel_q]  = 1'b0;
            cnt_d[sel_q] = cnt_inc;
            if (cnt_inc == CNT_MAX) fault_d[sel_q] = 1'b1;
          end
          default: ok_d[sel_q] = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= '0;
      fault_q <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) cnt_q[i] <= '0;
    end else begin
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sensor_poll_ctrl.sv
// Directed bench for sensor_poll_ctrl with a transaction-level reference model.
// A responder answers each request after a per-sensor delay with per-sensor data.
module tb_sensor_poll_ctrl;

  localparam int N  = 4;
  localparam int FT = 3;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] ok_o;
  logic [N-1:0] fault_o;
  logic         scan_done_o;
  logic         timeout_o;

  sensor_poll_ctrl_if #(.NUM_SENSORS(N)) bus ();

  sensor_poll_ctrl #(
    .NUM_SENSORS  (N),
    .FAULT_THRESH (FT),
    .TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bus         (bus),
    .ok_o        (ok_o),
    .fault_o     (fault_o),
    .scan_done_o (scan_done_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder configuration: delay d means ack in the (d+1)-th request cycle; -1 never acks.
  int         rsp_delay [N];
  logic [2:0] rsp_data  [N];
  logic       ack_noise = 1'b0;

  initial begin
    int rc;
    rc = 0;
    bus.ack_i  = 1'b0;
    bus.data_i = 3'b000;
    forever begin
      @(posedge clk);
      #2;
      if (bus.req_o) begin
        rc++;
        bus.ack_i = (rsp_delay[bus.sel_o] >= 0) && (rc == rsp_delay[bus.sel_o] + 1);
      end else begin
        rc = 0;
        bus.ack_i = ack_noise;
      end
      bus.data_i = rsp_data[bus.sel_o];
    end
  end

  // Reference model: 0 = idle, 1 = request outstanding, 2 = result being applied.
  int         m_phase, m_waited, m_sel, m_result;
  int         m_cnt [N];
  logic [N-1:0] e_ok, e_fault;
  logic       e_done, e_tmo;

  function automatic int reading_class(input logic [2:0] d);
    if (d >= 3'd4) return 0;
    if (d == 3'd3) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_waited = 0; m_sel = 0; m_result = 2;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    e_ok = '0; e_fault = '0; e_done = 1'b0; e_tmo = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        e_done = 1'b0;
        e_tmo  = 1'b0;
        case (m_phase)
          0: if (enable) begin m_phase = 1; m_waited = 0; end
          1: begin
            m_waited++;
            if (bus.ack_i) begin
              m_result = reading_class(bus.data_i);
              m_phase  = 2;
            end else if (m_waited == TO) begin
              m_result = 1;
              e_tmo    = 1'b1;
              m_phase  = 2;
            end
          end
          default: begin
            if (m_result == 0) begin
              e_ok[m_sel] = 1'b1; e_fault[m_sel] = 1'b0; m_cnt[m_sel] = 0;
            end else if (m_result == 1) begin
              e_ok[m_sel] = 1'b0;
              if (m_cnt[m_sel] < FT) m_cnt[m_sel]++;
              if (m_cnt[m_sel] == FT) e_fault[m_sel] = 1'b1;
            end else begin
              e_ok[m_sel] = 1'b0;
            end
            if (m_sel == N - 1) e_done = 1'b1;
            if (enable) begin
              m_sel = (m_sel + 1) % N; m_phase = 1; m_waited = 0;
            end else begin
              m_sel = 0; m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_req", bus.req_o, (m_phase == 1));
        check("m_sel", bus.sel_o, m_sel);
        check("m_ok", ok_o, e_ok);
        check("m_fault", fault_o, e_fault);
        check("m_done", scan_done_o, e_done);
        check("m_tmo", timeout_o, e_tmo);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin step(); n++; end while (!scan_done_o && n < budget);
    check("scan_done_seen", scan_done_o, 1);
  endtask

  task automatic wait_req_on(input int s, input int budget);
    int n;
    n = 0;
    while (!(bus.req_o && bus.sel_o == s) && n < budget) begin step(); n++; end
    check("req_on_sensor", {bus.req_o, 2'(bus.sel_o)}, {1'b1, 2'(s)});
  endtask

  task automatic count_req_cycles(output int n);
    n = 1;
    step();
    while (bus.req_o && n < 40) begin n++; step(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin rsp_delay[i] = 0; rsp_data[i] = 3'b100; end
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_req", bus.req_o, 0);
    check("rst_sel", bus.sel_o, 0);
    check("rst_ok", ok_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_done", scan_done_o, 0);
    check("rst_tmo", timeout_o, 0);

    // Best-case scan: IDLE in cycle 0, four REQ/EVAL pairs, scan_done in cycle 9.
    rst_n = 1'b1; enable = 1'b1;
    repeat (8) step();
    check("c8_ok", ok_o, 4'b0111);
    check("c8_done", scan_done_o, 0);
    step();
    check("c9_ok", ok_o, 4'b1111);
    check("c9_done", scan_done_o, 1);
    check("c9_fault", fault_o, 0);

    // Asynchronous reset in the middle of the request to sensor 1.
    step(); step();
    check("mid_req_before", bus.req_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", bus.req_o, 0);
    check("arst_sel", bus.sel_o, 0);
    check("arst_ok", ok_o, 0);

    // Priority: 111 is OK, 011 is FAULT, 001 is UNKNOWN and holds the counter.
    rsp_data[0] = 3'b111;
    step();
    rst_n = 1'b1;
    wait_done(40);
    check("p111_ok", ok_o, 4'b1111);
    rsp_data[0] = 3'b011;
    wait_done(40);
    check("p011_ok", ok_o, 4'b1110);
    check("p011_fault", fault_o, 4'b0000);
    rsp_data[0] = 3'b001;
    wait_done(40);
    check("p001_ok", ok_o, 4'b1110);
    rsp_data[0] = 3'b011;
    wait_done(40);
    check("p_cnt2_fault", fault_o, 4'b0000);
    wait_done(40);
    check("p_cnt3_fault", fault_o, 4'b0001);

    // Debounce on sensor 2, then clear by an OK reading.
    rsp_data[0] = 3'b100;
    rsp_data[2] = 3'b011;
    wait_done(40);
    check("d1_fault", fault_o, 4'b0000);
    check("d1_ok", ok_o, 4'b1011);
    wait_done(40);
    check("d2_fault", fault_o, 4'b0000);
    wait_done(40);
    check("d3_fault", fault_o, 4'b0100);
    rsp_data[2] = 3'b101;
    wait_done(40);
    check("d_clear_fault", fault_o, 4'b0000);
    check("d_clear_ok", ok_o, 4'b1111);
    rsp_data[2] = 3'b011;
    wait_done(40);
    check("d_cnt_cleared", fault_o, 4'b0000);
    rsp_data[2] = 3'b100;

    // Sensor 1 never acks: 15 request cycles, one timeout pulse, then sensor 2.
    rsp_delay[1] = -1;
    wait_req_on(1, 20);
    count_req_cycles(n);
    check("to_req_cycles", n, TO);
    check("to_pulse", timeout_o, 1);
    check("to_eval_sel", bus.sel_o, 1);
    step();
    check("to_sel_adv", bus.sel_o, 2);
    check("to_pulse_once", timeout_o, 0);
    wait_done(80);
    check("to1_fault", fault_o, 4'b0000);
    wait_done(80);
    wait_done(80);
    check("to3_fault", fault_o, 4'b0010);
    check("to3_ok", ok_o, 4'b1101);

    // Ack in the 15th wait cycle beats the timeout.
    rsp_delay[1] = TO - 1;
    wait_done(80);
    check("late_ack_ok", ok_o, 4'b1111);
    check("late_ack_fault", fault_o, 4'b0000);

    // Enable drops while sensor 1 waits on a 5-cycle-late ack.
    rsp_delay[1] = 5;
    rsp_data[1] = 3'b011;
    wait_req_on(1, 30);
    enable = 1'b0;
    count_req_cycles(n);
    check("drop_req_cycles", n, 6);
    check("drop_eval_sel", bus.sel_o, 1);
    step();
    check("drop_idle_req", bus.req_o, 0);
    check("drop_idle_sel", bus.sel_o, 0);
    check("drop_no_done", scan_done_o, 0);
    check("drop_evaluated", ok_o, 4'b1101);

    // Acks while idle are ignored.
    ack_noise = 1'b1;
    repeat (5) step();
    check("noise_req", bus.req_o, 0);
    check("noise_ok", ok_o, 4'b1101);
    ack_noise = 1'b0;
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
